// File: rtl/ifetch_queue.sv
// Instruction fetch front end: a single outstanding memory request feeding a
// circular queue that hands decode one instruction per cycle.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH_LOG = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        stall,
  input  logic        clr_flg,
  input  logic [31:0] clr_pc,
  output logic        ins_flg,
  output logic [31:0] ins,
  output logic [31:0] pc
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e               state_q;
  logic [31:0]          fetch_pc_q;
  logic                 mem_req_q;
  logic [31:0]          mem_addr_q;
  logic                 ins_flg_q;
  logic [31:0]          ins_q;
  logic [31:0]          pc_q;
  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [31:0]          ins_mem_q [DEPTH];
  logic [31:0]          pc_mem_q  [DEPTH];

  logic deq;
  logic enq;
  logic issue;

  // A flush outranks everything; a slot is reserved when the request issues.
  always_comb begin
    deq   = (count_q != '0) && !stall && !clr_flg;
    enq   = (state_q == FETCH) && mem_done && !clr_flg;
    issue = (state_q == IDLE) && !clr_flg && (count_q < FULL);
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr_flg) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) begin
        head_d = head_q + 1'b1;
      end else begin
        head_d = head_q;
      end
      if (enq) begin
        tail_d = tail_q + 1'b1;
      end else begin
        tail_d = tail_q;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue storage; the stored PC is the address the request was issued with.
  always_ff @(posedge clk_in) begin
    if (rdy_in && enq) begin
      ins_mem_q[tail_q] <= mem_data;
      pc_mem_q[tail_q]  <= mem_addr_q;
    end
  end

  // Fetch FSM, queue pointers and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      ins_flg_q  <= 1'b0;
      ins_q      <= 32'h0000_0000;
      pc_q       <= 32'h0000_0000;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;

      if (deq) begin
        ins_q     <= ins_mem_q[head_q];
        pc_q      <= pc_mem_q[head_q];
        ins_flg_q <= 1'b1;
      end else begin
        ins_flg_q <= 1'b0;
      end

      if (clr_flg) begin
        fetch_pc_q <= clr_pc;
      end else if (enq) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end

      // A flushed request keeps mem_req up until memory answers it.
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        FETCH: begin
          if (mem_done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else if (clr_flg) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (mem_done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ins_flg  = ins_flg_q & rdy_in;
  assign ins      = ins_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed cycle table, hand-written corner sequences
// and a randomized run checked by a request/queue-level scoreboard.
module tb_ifetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DMASK    = 32'hDEAD_BEEF;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        stall;
  logic        clr_flg;
  logic [31:0] clr_pc;
  logic        ins_flg;
  logic [31:0] ins;
  logic [31:0] pc;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH_LOG(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .stall(stall), .clr_flg(clr_flg), .clr_pc(clr_pc),
    .ins_flg(ins_flg), .ins(ins), .pc(pc)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Memory model: answers each request after lat cycles; frozen while rdy_in is low.
  bit rnd_mode = 0;
  int lat = 2;
  int cnt = 0;
  always @(negedge clk_in) begin
    #1;
    if (rst_in) begin
      cnt = 0;
      mem_done = 1'b0;
    end else if (!rdy_in) begin
      mem_done = 1'b0;
    end else if (mem_req && !mem_done) begin
      if (cnt == 0 && rnd_mode) lat = $urandom_range(1, 4);
      cnt++;
      if (cnt >= lat) begin
        mem_done = 1'b1;
        mem_data = rnd_mode ? $urandom : (mem_addr ^ DMASK);
        cnt = 0;
      end
    end else begin
      mem_done = 1'b0;
      if (!mem_req) cnt = 0;
    end
  end

  // Scoreboard: expected stream = accepted responses in order; fetch PC advances by 4.
  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  ent_t        e;
  logic [31:0] exp_pc = RESET_PC;
  bit          poison = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] last_ins = 32'h0, last_pc = 32'h0;
  logic        s_rst, s_rdy, s_stall, s_clr, s_done;
  logic [31:0] s_clrpc, s_data;
  int          pre_cnt;
  logic        exp_flg, exp_req;

  always @(posedge clk_in) begin
    s_rst = rst_in; s_rdy = rdy_in; s_stall = stall; s_clr = clr_flg;
    s_clrpc = clr_pc; s_done = mem_done; s_data = mem_data;
    #1;
    if (s_rst || rst_in) begin
      mq.delete();
      exp_pc = RESET_PC;
      poison = 0;
    end else if (!s_rdy) begin
      chk("sb_frozen_flg", ins_flg, 1'b0);
      chk("sb_frozen_req", mem_req, prev_req);
      chk("sb_frozen_addr", mem_addr, prev_addr);
    end else begin
      pre_cnt = mq.size();
      exp_flg = (pre_cnt > 0) && !s_stall && !s_clr;
      exp_req = prev_req ? !s_done : ((pre_cnt < 4) && !s_clr);
      chk("sb_req", mem_req, exp_req);
      if (!prev_req && exp_req) chk("sb_issue_addr", mem_addr, exp_pc);
      else chk("sb_addr_hold", mem_addr, prev_addr);
      chk("sb_flg", ins_flg, exp_flg);
      if (exp_flg) begin
        e = mq.pop_front();
        if (ins_flg) begin
          chk("sb_pc", pc, e.pc);
          chk("sb_ins", ins, e.ins);
        end
      end else begin
        chk("sb_pc_hold", pc, last_pc);
        chk("sb_ins_hold", ins, last_ins);
      end
      if (s_clr) begin
        mq.delete();
        exp_pc = s_clrpc;
        poison = prev_req && !s_done;
      end else if (prev_req && s_done) begin
        if (poison) poison = 0;
        else begin
          mq.push_back('{ins: s_data, pc: prev_addr});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    prev_req = mem_req; prev_addr = mem_addr; last_ins = ins; last_pc = pc;
  end

  typedef struct {
    logic        stall; logic clr; logic [31:0] clr_pc;
    logic        exp_req; logic [31:0] exp_addr; logic exp_flg; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(logic s, logic c, logic [31:0] cp, logic r, logic [31:0] a,
                              logic f, logic [31:0] p);
    vec_t v;
    v.stall = s; v.clr = c; v.clr_pc = cp; v.exp_req = r; v.exp_addr = a; v.exp_flg = f; v.exp_pc = p;
    return v;
  endfunction

  task automatic wait_req_rise(output logic [31:0] addr);
    logic was = mem_req;
    bit   ok = 0;
    addr = 32'h0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk_in); #1;
      if (mem_req && !was) begin ok = 1; addr = mem_addr; end
      was = mem_req;
    end
    if (!ok) chk("req_rise_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(input string name, input logic [31:0] epc);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_in); #1;
      if (ins_flg) begin
        got = 1;
        chk(name, pc, epc);
        chk({name, "_ins"}, ins, epc ^ DMASK);
      end
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0;
    logic [31:0] rise_addr;
    logic        was;
    logic [31:0] r;

    rst_in = 1'b1; rdy_in = 1'b1; stall = 1'b0; clr_flg = 1'b0; clr_pc = 32'h0;
    tbl[0]  = mk(0, 0, 0, 1, 32'h0,   0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 32'h0,   0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 32'h0,   0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 32'h4,   1, 32'h0);
    tbl[4]  = mk(0, 0, 0, 1, 32'h4,   0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 32'h4,   0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 32'h8,   1, 32'h4);
    tbl[7]  = mk(0, 0, 0, 1, 32'h8,   0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 32'h8,   0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 32'hC,   1, 32'h8);
    tbl[10] = mk(0, 1, 32'h100, 1, 32'hC, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 32'hC,   0, 0);
    tbl[12] = mk(0, 0, 0, 1, 32'h100, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 32'h100, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 32'h100, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 32'h104, 1, 32'h100);

    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_req", mem_req, 1'b0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_flg", ins_flg, 1'b0);
    chk("reset_ins", ins, 32'h0);
    chk("reset_pc", pc, 32'h0);
    @(negedge clk_in); rst_in = 1'b0;

    // Cycle-exact table: fetch 0,4,8 then a flush to 0x100 while fetching 12.
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall; clr_flg = tbl[i].clr; clr_pc = tbl[i].clr_pc;
      @(posedge clk_in); #1;
      chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].exp_req);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_flg", i), ins_flg, tbl[i].exp_flg);
      if (tbl[i].exp_flg) begin
        chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_ins", i), ins, tbl[i].exp_pc ^ DMASK);
      end
      @(negedge clk_in);
    end
    clr_flg = 1'b0;

    // Stall until the queue is full, then drain four in a row.
    stall = 1'b1;
    repeat (20) @(posedge clk_in);
    #1; chk("full_no_req", mem_req, 1'b0);
    @(negedge clk_in); stall = 1'b0;
    was = mem_req; rise_addr = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      chk($sformatf("drain%0d_flg", k), ins_flg, 1'b1);
      chk($sformatf("drain%0d_pc", k), pc, 32'h104 + 32'(4 * k));
      if (mem_req && !was && rise_addr == 32'hFFFF_FFFF) rise_addr = mem_addr;
      was = mem_req;
    end
    chk("resume_addr", rise_addr, 32'h114);

    // Flush in the same cycle as mem_done: no DROP, next request to clr_pc.
    wait_req_rise(a0);
    @(negedge clk_in);
    @(negedge clk_in); clr_flg = 1'b1; clr_pc = 32'h200;
    @(posedge clk_in); #1;
    chk("clr_done_req_low", mem_req, 1'b0);
    @(negedge clk_in); clr_flg = 1'b0;
    @(posedge clk_in); #1;
    chk("clr_done_req", mem_req, 1'b1);
    chk("clr_done_addr", mem_addr, 32'h200);
    wait_out("clr_done_first_pc", 32'h200);

    // Freeze with rdy_in low for five cycles during a fetch.
    wait_req_rise(a0);
    @(negedge clk_in); rdy_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_in); #1;
      chk("frozen_flg", ins_flg, 1'b0);
      chk("frozen_req", mem_req, 1'b1);
      chk("frozen_addr", mem_addr, a0);
    end
    @(negedge clk_in); rdy_in = 1'b1;
    wait_out("unfrozen_pc", a0);

    // Randomized traffic against the scoreboard.
    rnd_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk_in);
      r       = $urandom;
      stall   = ($urandom_range(0, 9) < 3);
      clr_flg = ($urandom_range(0, 39) == 0);
      clr_pc  = {r[31:2], 2'b00};
      rdy_in  = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk_in);
    stall = 1'b0; clr_flg = 1'b0; rdy_in = 1'b1; rnd_mode = 0; lat = 2;
    repeat (10) @(posedge clk_in);

    // Asynchronous reset in the middle of a fetch.
    wait_req_rise(a0);
    @(negedge clk_in); #2; rst_in = 1'b1; #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_addr", mem_addr, 32'h0);
    chk("async_rst_flg", ins_flg, 1'b0);
    chk("async_rst_ins", ins, 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("post_rst_req", mem_req, 1'b1);
    chk("post_rst_addr", mem_addr, RESET_PC);
    wait_out("post_rst_first_pc", RESET_PC);
    repeat (5) @(posedge clk_in);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Front-end instruction fetch unit with a small instruction queue.
- Owns the architectural fetch PC and requests one 32-bit word at a time from the memory controller/icache via a level req/done handshake.
- Buffers fetched words with their PCs and presents one instruction per cycle to the decode/issue stage as ins_flg/ins/pc, throttled by downstream stall.
- Redirected (flushed) by the commit stage on mispredict/jump; no branch prediction (always PC+4).

Parameters:
- RESET_PC, 32'h0, fetch PC after reset.
- DEPTH_LOG, 2, log2 of queue depth (DEPTH = 4 entries).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global ready; when 0 all internal state holds.
- mem_req  output  1  fetch request, level; held until mem_done.
- mem_addr  output  32  fetch address, stable while mem_req=1.
- mem_done  input  1  one-cycle pulse: mem_data valid for the current request.
- mem_data  input  32  fetched instruction word.
- stall  input  1  downstream cannot accept an instruction this cycle.
- clr_flg  input  1  flush/redirect pulse from commit.
- clr_pc  input  32  new fetch PC when clr_flg=1.
- ins_flg  output  1  registered; ins/pc valid this cycle (one instruction).
- ins  output  32  registered instruction word.
- pc  output  32  registered PC of ins.

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC; queue empty (head = tail = count = 0); state IDLE.
  - mem_req = 0, mem_addr = 0, ins_flg = 0, ins = 0, pc = 0.
- rdy_in = 0: no register changes at all; ins_flg is forced 0 while rdy_in = 0.
- Storage: DEPTH entries of {ins, pc}; circular, head/tail wrap modulo DEPTH; count 0..DEPTH.
- FSM states:
  - IDLE: if count < DEPTH and no clr_flg, assert mem_req with mem_addr = fetch_pc at the next edge, then go to FETCH.
  - FETCH: mem_req = 1, mem_addr held. On mem_done, write {mem_data, mem_addr} at tail, fetch_pc += 4 (wraps mod 2^32), then go to IDLE with mem_req = 0.
  - DROP: mem_req stays 1 with the old address. On mem_done, discard the data and go to IDLE. Nothing is written to the queue.
- At most one request outstanding. The slot is reserved at issue (count < DEPTH checked in IDLE), so a response is never dropped for lack of space.
- Back-to-back requests: mem_req drops for at least one cycle between requests (IDLE cycle).
- Dequeue:
  - At each edge, if count > 0, !stall and !clr_flg: ins/pc <= head entry, ins_flg <= 1, and head advances.
  - Otherwise ins_flg <= 0; ins/pc hold their last value.
- Latency: a word accepted at edge E is at the earliest presented (ins_flg = 1) after edge E+1. There is no bypass from mem_data to outputs.
- Enqueue and dequeue on the same edge: count unchanged; must work at count = DEPTH-1 and count = 1.
- clr_flg (highest priority):
  - queue emptied, fetch_pc <= clr_pc, ins_flg <= 0.
  - From FETCH without mem_done: go to DROP.
  - From FETCH with mem_done in the same cycle: discard data, go to IDLE.
  - From DROP or IDLE: stay in / go to the corresponding state with the new pc; no extra request is issued in that cycle.
- clr_flg while in DROP: update fetch_pc again and stay in DROP.

Test Plan:
- Reset, stall = 0, memory returns done 2 cycles after req:
  - mem_addr sequence is 0, 4, 8.
  - ins_flg pulses carry pc 0, 4, 8 with matching ins.
  - First ins_flg appears 2 edges after the first mem_done.
- stall = 1 held:
  - After 4 fetches mem_req stays 0 (count = 4).
  - Release stall: 4 consecutive ins_flg cycles with pc 0, 4, 8, 12 in order, then fetching resumes at 16.
- clr_flg with clr_pc = 32'h100 while in FETCH (addr 8):
  - Queue cleared; next ins_flg = 0.
  - Late mem_done for addr 8 is discarded.
  - Next mem_addr = 0x100; first output pc = 0x100.
- clr_flg and mem_done in the same cycle: data is not enqueued, no DROP state; next request is to clr_pc.
- rdy_in = 0 for 5 cycles mid-FETCH: no state change, ins_flg = 0, mem_req/mem_addr held; on resume, output sequence continues without loss or duplication.
- Assert rst_in asynchronously mid-FETCH:
  - Outputs go to 0 immediately.
  - After release, the first mem_addr is RESET_PC.
